snake_heading_engine: RTL and testbench
=======================================

Name: snake_heading_engine

Overview:
- Consumer end of the key-reader control interface: decodes the 2-bit control code latched once per game step and drives the snake head's heading and grid position.
- Runs on the 50 MHz system clock.
- Detects game-step edges from the raw step clock internally.
- Outputs feed the body/collision logic and the VGA renderer.

Parameters:
- GRID_W, 32, grid columns; x range 0..GRID_W-1.
- GRID_H, 24, grid rows; y range 0..GRID_H-1.
- X_W, 5, head_x width; must satisfy 2^X_W >= GRID_W.
- Y_W, 5, head_y width; must satisfy 2^Y_W >= GRID_H.
- START_X, 16, head x after reset.
- START_Y, 12, head y after reset.
- START_DIR, 0, heading after reset (0=E, 1=S, 2=W, 3=N).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; asynchronous, active-low.
- step_clk  in  1  raw game-step clock, asynchronous to clk. The control code updates on its rising edge.
- control  in  2  code from key reader: 00=turn CCW, 01=turn CW, 10=pause/resume toggle, 11=no action.
- head_x  out  X_W  head column.
- head_y  out  Y_W  head row; y increases southward.
- heading  out  2  current direction: 00=E, 01=S, 10=W, 11=N.
- moved  out  1  one-cycle pulse; the head advanced one cell.
- wrapped  out  1  one-cycle pulse, coincident with moved, when the advance crossed a grid edge.
- paused  out  1  high in the PAUSE state.
- started  out  1  low in the WAIT state, high otherwise.

Behaviour:
- Reset values, async on rst low:
  - head_x=START_X, head_y=START_Y, heading=START_DIR.
  - moved=0, wrapped=0, paused=0, started=0, state=WAIT.
  - Both synchronizer flops and the edge-history flop reset to 1, so a step_clk held high at release produces no spurious step.
- Step detection:
  - step_clk passes through a 2-flop synchronizer, then rising-edge detection.
  - The step strobe is high for exactly one clk cycle, 2-3 clk cycles after the step_clk rise.
  - control is sampled in the strobe cycle. It is guaranteed stable there, having been set by the same step_clk edge.
- All outputs are registered. Effects of a strobe appear in the following cycle. moved and wrapped deassert one cycle later.
- Turn arithmetic, mod 4: CW gives heading+1, CCW gives heading-1. Examples: N(3)+CW gives E(0); E(0)+CCW gives N(3). A 180-degree reversal is impossible by construction.
- Move arithmetic, applied with the post-turn heading:
  - E: x+1. At x=GRID_W-1, x becomes 0 and wrapped=1.
  - W: x-1. At x=0, x becomes GRID_W-1 and wrapped=1.
  - S: y+1. At y=GRID_H-1, y becomes 0 and wrapped=1.
  - N: y-1. At y=0, y becomes GRID_H-1 and wrapped=1.
  - Non-power-of-2 grids must wrap at GRID_W/GRID_H, not at 2^width.
- FSM transitions on a strobe:
  - WAIT, code 11: stay in WAIT, no move.
  - WAIT, code 00/01: turn, move, go to RUN.
  - WAIT, code 10: go to RUN, no move.
  - RUN, code 11: move straight.
  - RUN, code 00/01: turn, then move, both on the same step.
  - RUN, code 10: go to PAUSE, no move, heading held.
  - PAUSE, code 00/01/11: ignored; heading and position held.
  - PAUSE, code 10: go to RUN, no move. Moves resume on the next strobe.
- No strobe: all state holds.
- Reset mid-step, including during the strobe cycle: reset wins immediately. The pending step is discarded.
- A strobe arriving while moved is still high from the prior step cannot occur: the step period is far greater than 3 clk cycles. No queuing is required.

Test Plan:
- Reset with step_clk high, release, run 10 clk cycles with no edge -> moved never asserts; head=(16,12), heading=0, started=0.
- WAIT, code 01 on the step edge -> within 4 clk cycles: heading=1, head=(16,13), moved one cycle, started=1.
- RUN heading E, head_x=31, code 11 -> head_x=0, wrapped and moved both pulse one cycle. With heading N and y=0 -> head_y=23.
- RUN heading N, code 01 -> heading=0; then code 00 -> heading=3. Each step moves one cell in the new direction.
- RUN, code 10 -> paused=1, no move. Then codes 00 and 11 for 2 steps -> heading and position unchanged. Then code 10 -> paused=0, no move. Then code 11 -> moved.
- Assert rst low 1 cycle after a strobe while in RUN at (5,5) -> outputs return to reset values immediately; no moved pulse afterward.

Source files
------------

// File: rtl/snake_heading_engine_if.sv
// Control/status bundle between the key reader (master) and the heading engine (slave).
interface snake_heading_engine_if #(
    parameter int X_W = 5,
    parameter int Y_W = 5
);
    logic [1:0]     control;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [1:0]     heading;
    logic           moved;
    logic           wrapped;
    logic           paused;
    logic           started;

    modport master (
        output control,
        input  head_x, head_y, heading, moved, wrapped, paused, started
    );

    modport slave (
        input  control,
        output head_x, head_y, heading, moved, wrapped, paused, started
    );
endinterface

// File: rtl/snake_heading_engine.sv
// Snake head steering: synchronizes the game-step clock, decodes the control
// code once per step and updates heading / grid position with toroidal wrap.
module snake_heading_engine #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_W       = 5,
    parameter int Y_W       = 5,
    parameter int START_X   = 16,
    parameter int START_Y   = 12,
    parameter int START_DIR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_clk,
    snake_heading_engine_if.slave bus
);
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] C_CCW   = 2'b00;
    localparam logic [1:0] C_CW    = 2'b01;
    localparam logic [1:0] C_PAUSE = 2'b10;

    localparam logic [1:0] D_E = 2'd0;
    localparam logic [1:0] D_S = 2'd1;
    localparam logic [1:0] D_W = 2'd2;

    localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [1:0]     D_START = 2'(START_DIR);

    // Synchronizer and edge history idle high so a high step_clk at release is not an edge.
    logic sync1_q, sync2_q, hist_q;
    logic step_stb;

    state_t         state_q, state_d;
    logic [X_W-1:0] head_x_q, head_x_d;
    logic [Y_W-1:0] head_y_q, head_y_d;
    logic [1:0]     heading_q, heading_d;
    logic           moved_q, moved_d;
    logic           wrapped_q, wrapped_d;
    logic           paused_q, paused_d;
    logic           started_q, started_d;

    logic [1:0]     dir_turn;
    logic [X_W-1:0] adv_x;
    logic [Y_W-1:0] adv_y;
    logic           adv_wrap;
    logic           do_move;

    assign step_stb = sync2_q & ~hist_q;

    // Heading after applying this step's turn code (CW +1, CCW -1, mod 4).
    always_comb begin
        dir_turn = heading_q;
        if (bus.control == C_CW) begin
            dir_turn = heading_q + 2'd1;
        end else if (bus.control == C_CCW) begin
            dir_turn = heading_q - 2'd1;
        end
    end

    // One-cell advance along the post-turn heading, wrapping at the grid size.
    always_comb begin
        adv_x    = head_x_q;
        adv_y    = head_y_q;
        adv_wrap = 1'b0;
        case (dir_turn)
            D_E: begin
                if (head_x_q == X_MAX) begin
                    adv_x    = '0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_x = head_x_q + X_W'(1);
                end
            end
            D_S: begin
                if (head_y_q == Y_MAX) begin
                    adv_y    = '0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_y = head_y_q + Y_W'(1);
                end
            end
            D_W: begin
                if (head_x_q == '0) begin
                    adv_x    = X_MAX;
                    adv_wrap = 1'b1;
                end else begin
                    adv_x = head_x_q - X_W'(1);
                end
            end
            default: begin
                if (head_y_q == '0) begin
                    adv_y    = Y_MAX;
                    adv_wrap = 1'b1;
                end else begin
                    adv_y = head_y_q - Y_W'(1);
                end
            end
        endcase
    end

    // Step decode: choose next state and whether this strobe moves the head.
    always_comb begin
        state_d = state_q;
        do_move = 1'b0;
        if (step_stb) begin
            case (state_q)
                S_WAIT: begin
                    if (bus.control == C_PAUSE) begin
                        state_d = S_RUN;
                    end else if (bus.control != 2'b11) begin
                        state_d = S_RUN;
                        do_move = 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.control == C_PAUSE) begin
                        state_d = S_PAUSE;
                    end else begin
                        do_move = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.control == C_PAUSE) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Next values for the registered outputs; pulses default low.
    always_comb begin
        head_x_d  = head_x_q;
        head_y_d  = head_y_q;
        heading_d = heading_q;
        moved_d   = 1'b0;
        wrapped_d = 1'b0;
        if (do_move) begin
            head_x_d  = adv_x;
            head_y_d  = adv_y;
            heading_d = dir_turn;
            moved_d   = 1'b1;
            wrapped_d = adv_wrap;
        end
        paused_d  = (state_d == S_PAUSE);
        started_d = (state_d != S_WAIT);
    end

    // All state, including the FSM and the step-clock synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b1;
            state_q   <= S_WAIT;
            head_x_q  <= X_START;
            head_y_q  <= Y_START;
            heading_q <= D_START;
            moved_q   <= 1'b0;
            wrapped_q <= 1'b0;
            paused_q  <= 1'b0;
            started_q <= 1'b0;
        end else begin
            sync1_q   <= step_clk;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            state_q   <= state_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            heading_q <= heading_d;
            moved_q   <= moved_d;
            wrapped_q <= wrapped_d;
            paused_q  <= paused_d;
            started_q <= started_d;
        end
    end

    assign bus.head_x  = head_x_q;
    assign bus.head_y  = head_y_q;
    assign bus.heading = heading_q;
    assign bus.moved   = moved_q;
    assign bus.wrapped = wrapped_q;
    assign bus.paused  = paused_q;
    assign bus.started = started_q;
endmodule

// File: tb/tb_snake_heading_engine.sv
// Bench for snake_heading_engine: directed table, wrap sequences, reset corners,
// then random codes checked against a grid-level reference model.
module tb_snake_heading_engine;
    localparam int GW = 32;
    localparam int GH = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic step_clk = 1'b1;

    snake_heading_engine_if #(.X_W(5), .Y_W(5)) bus ();

    snake_heading_engine #(
        .GRID_W(GW), .GRID_H(GH), .X_W(5), .Y_W(5),
        .START_X(16), .START_Y(12), .START_DIR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step_clk(step_clk),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model: position, direction, mode (0 wait, 1 run, 2 pause).
    int mx, my, mdir, mmode, m_moved, m_wrap;

    typedef struct {
        logic [1:0] code;
        int x, y, dir, moved, wrapped, paused, started;
    } vec_t;

    typedef struct {
        int x, y, dir, mcnt, wcnt, walone, lat_ok, paused, started;
    } obs_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mx = 16; my = 12; mdir = 0; mmode = 0; m_moved = 0; m_wrap = 0;
    endfunction

    function automatic void model_advance();
        int nx, ny;
        nx = mx; ny = my;
        case (mdir)
            0: nx = mx + 1;
            1: ny = my + 1;
            2: nx = mx - 1;
            default: ny = my - 1;
        endcase
        m_wrap  = (nx < 0 || nx >= GW || ny < 0 || ny >= GH) ? 1 : 0;
        mx      = (nx + GW) % GW;
        my      = (ny + GH) % GH;
        m_moved = 1;
    endfunction

    function automatic void model_apply(input int code);
        m_moved = 0; m_wrap = 0;
        if (code == 2) begin
            mmode = (mmode == 1) ? 2 : 1;
        end else if (mmode == 2) begin
            // paused: ignore turns and straight codes
        end else if (mmode == 0 && code == 3) begin
            // waiting for the first real command
        end else begin
            if (code == 1) mdir = (mdir + 1) % 4;
            if (code == 0) mdir = (mdir + 3) % 4;
            mmode = 1;
            model_advance();
        end
    endfunction

    // Raise step_clk with a new code, watch the output window, then drop step_clk.
    task automatic do_step(input logic [1:0] code, output obs_t o);
        int first;
        first = -1;
        o.mcnt = 0; o.wcnt = 0; o.walone = 0;
        @(negedge clk);
        step_clk = 1'b1;
        bus.control = code;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.moved) begin
                o.mcnt++;
                if (first < 0) first = i;
            end
            if (bus.wrapped && bus.moved) o.wcnt++;
            if (bus.wrapped && !bus.moved) o.walone++;
        end
        o.lat_ok  = (first >= 0 && first <= 3) ? 1 : 0;
        o.x       = int'(bus.head_x);
        o.y       = int'(bus.head_y);
        o.dir     = int'(bus.heading);
        o.paused  = int'(bus.paused);
        o.started = int'(bus.started);
        step_clk = 1'b0;
        repeat (4) @(negedge clk);
        $display("step code=%0d -> x=%0d y=%0d dir=%0d moved=%0d wrapped=%0d paused=%0d started=%0d",
                 code, o.x, o.y, o.dir, o.mcnt, o.wcnt, o.paused, o.started);
    endtask

    task automatic check_obs(input string tag, input obs_t o, input vec_t e);
        chk({tag, ".head_x"}, o.x, e.x);
        chk({tag, ".head_y"}, o.y, e.y);
        chk({tag, ".heading"}, o.dir, e.dir);
        chk({tag, ".moved_pulses"}, o.mcnt, e.moved);
        chk({tag, ".wrapped_pulses"}, o.wcnt, e.wrapped);
        chk({tag, ".wrapped_without_moved"}, o.walone, 0);
        chk({tag, ".paused"}, o.paused, e.paused);
        chk({tag, ".started"}, o.started, e.started);
        if (e.moved == 1) chk({tag, ".latency_ok"}, o.lat_ok, 1);
    endtask

    task automatic model_step(input string tag, input logic [1:0] code);
        obs_t o;
        vec_t e;
        model_apply(int'(code));
        do_step(code, o);
        e.code = code; e.x = mx; e.y = my; e.dir = mdir;
        e.moved = m_moved; e.wrapped = m_wrap;
        e.paused = (mmode == 2) ? 1 : 0;
        e.started = (mmode != 0) ? 1 : 0;
        check_obs(tag, o, e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".head_x"}, int'(bus.head_x), 16);
        chk({tag, ".head_y"}, int'(bus.head_y), 12);
        chk({tag, ".heading"}, int'(bus.heading), 0);
        chk({tag, ".moved"}, int'(bus.moved), 0);
        chk({tag, ".wrapped"}, int'(bus.wrapped), 0);
        chk({tag, ".paused"}, int'(bus.paused), 0);
        chk({tag, ".started"}, int'(bus.started), 0);
    endtask

    // Raise step_clk, assert rst after `delay` negedges, then release with step_clk still high.
    task automatic reset_mid_step(input string tag, input int delay, input logic [1:0] code);
        int mc;
        @(negedge clk);
        step_clk = 1'b1;
        bus.control = code;
        repeat (delay) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.moved) mc++;
        end
        chk({tag, ".moved_after_release"}, mc, 0);
        chk({tag, ".head_x_after"}, int'(bus.head_x), 16);
        chk({tag, ".started_after"}, int'(bus.started), 0);
        step_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        $display("reset %s: x=%0d y=%0d dir=%0d started=%0d", tag,
                 bus.head_x, bus.head_y, bus.heading, bus.started);
    endtask

    vec_t tbl[11];

    initial begin
        obs_t o;
        int mc;
        logic [1:0] seq_codes[$];

        tbl[0]  = '{2'b01, 16, 13, 1, 1, 0, 0, 1};
        tbl[1]  = '{2'b11, 16, 14, 1, 1, 0, 0, 1};
        tbl[2]  = '{2'b00, 17, 14, 0, 1, 0, 0, 1};
        tbl[3]  = '{2'b00, 17, 13, 3, 1, 0, 0, 1};
        tbl[4]  = '{2'b01, 18, 13, 0, 1, 0, 0, 1};
        tbl[5]  = '{2'b00, 18, 12, 3, 1, 0, 0, 1};
        tbl[6]  = '{2'b10, 18, 12, 3, 0, 0, 1, 1};
        tbl[7]  = '{2'b00, 18, 12, 3, 0, 0, 1, 1};
        tbl[8]  = '{2'b11, 18, 12, 3, 0, 0, 1, 1};
        tbl[9]  = '{2'b10, 18, 12, 3, 0, 0, 0, 1};
        tbl[10] = '{2'b11, 18, 11, 3, 1, 0, 0, 1};

        bus.control = 2'b11;
        model_reset();

        // Reset with step_clk held high, then idle: no step may appear.
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        mc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.moved) mc++;
        end
        chk("release_no_step", mc, 0);
        check_reset_values("idle");
        step_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Directed table from the reset position.
        for (int i = 0; i < 11; i++) begin
            model_apply(int'(tbl[i].code));
            do_step(tbl[i].code, o);
            check_obs($sformatf("tbl%0d", i), o, tbl[i]);
        end

        // Edge wraps: north to y=0 then over, east to x=31 then over, south, west.
        for (int i = 0; i < 12; i++) seq_codes.push_back(2'b11);
        seq_codes.push_back(2'b01);
        for (int i = 0; i < 12; i++) seq_codes.push_back(2'b11);
        seq_codes.push_back(2'b11);
        seq_codes.push_back(2'b01);
        seq_codes.push_back(2'b01);
        foreach (seq_codes[k]) model_step($sformatf("wrap%0d", k), seq_codes[k]);

        // Reset one cycle after the strobe while running.
        reset_mid_step("rst_after_strobe", 3, 2'b11);

        // Reset landing in the strobe cycle itself.
        model_step("rearm", 2'b01);
        reset_mid_step("rst_in_strobe", 2, 2'b11);

        // Random codes against the model.
        for (int k = 0; k < 80; k++) begin
            model_step($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
